sram_port_arbiter: RTL and testbench

Round-robin arbiter sharing the demo system's single-port SRAM between `NumHosts` OBI-style requesters (instruction fetch, data, debug/DMA). Grants one request per cycle, drives the SRAM port, and routes the fixed one-cycle SRAM response back to the granted host. Out-of-window addresses are absorbed locally with an error response. Sits between the Ibex core/debug bus hosts and the generic RAM inside `ibex_demo_system`.

---
 rtl/sram_port_arbiter.sv | 101 ++++++++++
 tb/tb_sram_port_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM among NumHosts OBI-style requesters.
// Zero-latency grant, fixed one-cycle response; out-of-window accesses answer with an error.
module sram_port_arbiter #(
   parameter int                   NumHosts  = 3,
   parameter int                   AddrWidth = 32,
   parameter int                   DataWidth = 32,
   parameter logic [AddrWidth-1:0] MemBase   = 32'h0010_0000,
   parameter int                   MemSize   = 65536,
   parameter int                   MemAw     = $clog2(MemSize / 4)
) (
   input  logic                              clk_sys_i,
   input  logic                              rst_sys_i,
   input  logic [NumHosts-1:0]               host_req_i,
   input  logic [NumHosts-1:0]               host_we_i,
   input  logic [NumHosts*AddrWidth-1:0]     host_addr_i,
   input  logic [NumHosts*(DataWidth/8)-1:0] host_be_i,
   input  logic [NumHosts*DataWidth-1:0]     host_wdata_i,
   output logic [NumHosts-1:0]               host_gnt_o,
   output logic [NumHosts-1:0]               host_rvalid_o,
   output logic                              host_err_o,
   output logic [DataWidth-1:0]              host_rdata_o,
   output logic                              mem_req_o,
   output logic                              mem_we_o,
   output logic [MemAw-1:0]                  mem_addr_o,
   output logic [DataWidth/8-1:0]            mem_be_o,
   output logic [DataWidth-1:0]              mem_wdata_o,
   input  logic [DataWidth-1:0]              mem_rdata_i
);

   localparam int                 BeWidth  = DataWidth / 8;
   localparam int                 RrW      = $clog2(NumHosts);
   localparam logic [AddrWidth:0] MemSizeW = (AddrWidth + 1)'(MemSize);

   logic [RrW-1:0]       rr_q;
   logic [NumHosts-1:0]  rsp_host_q;
   logic                 rsp_valid_q;
   logic                 rsp_err_q;

   logic [RrW-1:0]       winner;
   logic                 granted;
   logic [NumHosts-1:0]  gnt;
   int                   scan_idx;
   logic [AddrWidth-1:0] win_addr;
   logic [AddrWidth:0]   offset;
   logic                 in_win;

   function automatic logic [RrW-1:0] wrap_inc(input logic [RrW-1:0] v);
      if (int'(v) == NumHosts - 1) return '0;
      return v + 1'b1;
   endfunction

   // Scan from rr_q upward, wrapping; first requester wins. Grants are held off during reset.
   always_comb begin
      winner   = '0;
      granted  = 1'b0;
      gnt      = '0;
      scan_idx = 0;
      for (int i = 0; i < NumHosts; i++) begin
         scan_idx = int'(rr_q) + i;
         if (scan_idx >= NumHosts) scan_idx = scan_idx - NumHosts;
         if (!granted && host_req_i[scan_idx]) begin
            granted = 1'b1;
            winner  = RrW'(scan_idx);
         end
      end
      if (rst_sys_i) granted = 1'b0;
      if (granted) gnt[winner] = 1'b1;
   end

   // Widened subtraction: an address below MemBase wraps to a huge offset and fails the bound.
   assign win_addr = host_addr_i[winner*AddrWidth +: AddrWidth];
   assign offset   = {1'b0, win_addr} - {1'b0, MemBase};
   assign in_win   = (offset < MemSizeW);

   assign host_gnt_o  = gnt;
   assign mem_req_o   = granted & in_win;
   assign mem_we_o    = host_we_i[winner];
   assign mem_addr_o  = offset[MemAw+1:2];
   assign mem_be_o    = host_be_i[winner*BeWidth +: BeWidth];
   assign mem_wdata_o = host_wdata_i[winner*DataWidth +: DataWidth];

   always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
      if (rst_sys_i) begin
         rr_q        <= '0;
         rsp_host_q  <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
      end else begin
         if (granted) rr_q <= wrap_inc(winner);
         rsp_host_q  <= gnt;
         rsp_valid_q <= granted;
         rsp_err_q   <= granted & ~in_win;
      end
   end

   // Response stage: SRAM data arrives this cycle for the host granted last cycle.
   assign host_rvalid_o = rsp_valid_q ? rsp_host_q : '0;
   assign host_err_o    = rsp_valid_q & rsp_err_q;
   assign host_rdata_o  = rsp_err_q ? '0 : mem_rdata_i;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed self-checking bench for sram_port_arbiter with a behavioural one-cycle SRAM model.
module tb_sram_port_arbiter;

  localparam logic [31:0] Base = 32'h0010_0000;
  localparam int          Size = 65536;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [2:0]    host_req = '0;
  logic [2:0]    host_we = '0;
  logic [95:0]   host_addr = '0;
  logic [11:0]   host_be = '0;
  logic [95:0]   host_wdata = '0;
  logic [2:0]    host_gnt;
  logic [2:0]    host_rvalid;
  logic          host_err;
  logic [31:0]   host_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [13:0]   mem_addr;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = '0;

  logic [31:0]   sram [0:16383];

  int checks = 0;
  int errors = 0;
  logic done = 1'b0;

  always #5 clk = ~clk;

  sram_port_arbiter dut (
    .clk_sys_i    (clk),
    .rst_sys_i    (rst),
    .host_req_i   (host_req),
    .host_we_i    (host_we),
    .host_addr_i  (host_addr),
    .host_be_i    (host_be),
    .host_wdata_i (host_wdata),
    .host_gnt_o   (host_gnt),
    .host_rvalid_o(host_rvalid),
    .host_err_o   (host_err),
    .host_rdata_o (host_rdata),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_be_o     (mem_be),
    .mem_wdata_o  (mem_wdata),
    .mem_rdata_i  (mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_req) begin
      mem_rdata <= sram[mem_addr];
      if (mem_we)
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) sram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_host(input int h, input logic req, input logic we,
                          input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wd);
    host_req[h]            = req;
    host_we[h]             = we;
    host_addr[h*32 +: 32]  = addr;
    host_be[h*4 +: 4]      = be;
    host_wdata[h*32 +: 32] = wd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    if (!done) begin
      errors++;
      $error("FAIL timeout: wait expired before stimulus completed");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  initial begin
    logic [2:0] exp_gnt;
    logic [2:0] exp_rv;

    sram[0] = 32'h1111_1111;
    sram[1] = 32'hAABB_CCDD;
    sram[2] = 32'hDEAD_BEEF;

    set_host(0, 1'b1, 1'b0, Base + 32'd8, 4'hF, 32'h0);
    #2;
    chk("rst_gnt", host_gnt, 3'b000);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_rvalid", host_rvalid, 3'b000);
    chk("rst_err", host_err, 1'b0);
    step();
    step();
    rst = 1'b0;

    #1;
    chk("rd0_gnt", host_gnt, 3'b001);
    chk("rd0_mem_req", mem_req, 1'b1);
    chk("rd0_mem_addr", mem_addr, 14'd2);
    chk("rd0_mem_we", mem_we, 1'b0);
    step();
    chk("rd0_rvalid", host_rvalid, 3'b001);
    chk("rd0_rdata", host_rdata, 32'hDEAD_BEEF);
    chk("rd0_err", host_err, 1'b0);
    set_host(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

    rst = 1'b1;
    step();
    rst = 1'b0;
    set_host(0, 1'b1, 1'b0, Base + 32'd0, 4'hF, 32'h0);
    set_host(1, 1'b1, 1'b0, Base + 32'd4, 4'hF, 32'h0);
    set_host(2, 1'b1, 1'b0, Base + 32'd8, 4'hF, 32'h0);
    #1;
    for (int c = 0; c < 9; c++) begin
      exp_gnt = 3'b001 << (c % 3);
      exp_rv  = (c == 0) ? 3'b000 : (3'b001 << ((c - 1) % 3));
      chk("rot_gnt", host_gnt, exp_gnt);
      chk("rot_mem_addr", mem_addr, 14'(c % 3));
      chk("rot_rvalid", host_rvalid, exp_rv);
      step();
    end
    chk("rot_last_rvalid", host_rvalid, 3'b100);
    set_host(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    set_host(2, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

    set_host(1, 1'b1, 1'b1, Base + 32'd4, 4'b0011, 32'h1234_5678);
    #1;
    chk("wr1_gnt", host_gnt, 3'b010);
    chk("wr1_mem_we", mem_we, 1'b1);
    chk("wr1_mem_be", mem_be, 4'b0011);
    chk("wr1_mem_wdata", mem_wdata, 32'h1234_5678);
    chk("wr1_mem_addr", mem_addr, 14'd1);
    step();
    chk("wr1_rvalid", host_rvalid, 3'b010);
    chk("wr1_err", host_err, 1'b0);
    set_host(1, 1'b1, 1'b0, Base + 32'd4, 4'hF, 32'h0);
    #1;
    chk("rd1_gnt", host_gnt, 3'b010);
    chk("rd1_mem_we", mem_we, 1'b0);
    step();
    chk("rd1_rvalid", host_rvalid, 3'b010);
    chk("rd1_rdata", host_rdata, 32'hAABB_5678);
    set_host(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

    set_host(2, 1'b1, 1'b0, Base + Size, 4'hF, 32'h0);
    #1;
    chk("oow_hi_gnt", host_gnt, 3'b100);
    chk("oow_hi_mem_req", mem_req, 1'b0);
    step();
    chk("oow_hi_rvalid", host_rvalid, 3'b100);
    chk("oow_hi_err", host_err, 1'b1);
    chk("oow_hi_rdata", host_rdata, 32'h0);
    set_host(2, 1'b1, 1'b0, Base - 32'd4, 4'hF, 32'h0);
    #1;
    chk("oow_lo_gnt", host_gnt, 3'b100);
    chk("oow_lo_mem_req", mem_req, 1'b0);
    step();
    chk("oow_lo_rvalid", host_rvalid, 3'b100);
    chk("oow_lo_err", host_err, 1'b1);
    chk("oow_lo_rdata", host_rdata, 32'h0);
    set_host(2, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

    set_host(0, 1'b1, 1'b0, Base + 32'd8, 4'hF, 32'h0);
    #1;
    chk("pre_gnt", host_gnt, 3'b001);
    step();
    chk("pre_rvalid", host_rvalid, 3'b001);
    chk("pre_rdata", host_rdata, 32'hDEAD_BEEF);
    chk("mid_gnt", host_gnt, 3'b001);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_gnt", host_gnt, 3'b000);
    chk("mid_rst_mem_req", mem_req, 1'b0);
    step();
    chk("mid_rst_rvalid", host_rvalid, 3'b000);
    rst = 1'b0;
    set_host(1, 1'b1, 1'b0, Base + 32'd4, 4'hF, 32'h0);
    #1;
    chk("post_rst_rvalid", host_rvalid, 3'b000);
    chk("post_rst_gnt", host_gnt, 3'b001);
    step();
    chk("post_rst_resp", host_rvalid, 3'b001);
    chk("post_rst_next_gnt", host_gnt, 3'b010);
    set_host(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    set_host(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    step();

    done = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
